bs_job_sequencer: RTL and testbench
===================================

Name: bs_job_sequencer

Overview:
- Host-side controller for the Black-Scholes processor.
- Accepts one job (niter plus three constants) from the M1-side front end over a valid/ready handshake.
- Drives the processor's constant inputs and command port (RUN, then ACK), watches its status, captures both sums at COMPLETE, and returns them over a valid/ready result handshake together with a cycle count and a timeout error flag.
- Sits between the M1 register front end and the processor; one job in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 32'd4000000, maximum cycles allowed from RUN issue to COMPLETE observed.
- CMD_RUN, 4'd1, processor command code for RUN.
- CMD_ACK, 4'd2, processor command code for ACK.
- ST_IDLE, 4'd0, processor status code for IDLE.
- ST_RUNNING, 4'd1, processor status code for RUNNING.
- ST_COMPLETE, 4'd2, processor status code for COMPLETE.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_ready  out  1  sequencer can accept a job
- job_niter  in  32  iteration count
- job_constK  in  64  K constant
- job_const1  in  64  S*exp(...) constant
- job_const2  in  64  sigma*sqrt(T) constant
- proc_niter  out  32  registered niter to processor
- proc_constK  out  64  registered constK to processor
- proc_const1  out  64  registered const1 to processor
- proc_const2  out  64  registered const2 to processor
- proc_cmd  out  4  processor command
- proc_status  in  4  processor state
- proc_sum  in  64  processor sum_dout
- proc_pow_sum  in  64  processor pow_sum_dout
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_sum  out  64  captured sum
- res_pow_sum  out  64  captured power sum
- res_cycles  out  32  cycles from RUN issue to COMPLETE observed
- res_err  out  1  timeout occurred
- busy  out  1  high in every state except S_IDLE

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - All outputs 0, with these exceptions: job_ready=1 and state S_IDLE.
  - proc_cmd=0, so no command is issued during or after reset.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- S_IDLE:
  - job_ready=1.
  - On job_valid&&job_ready, latch the job_* fields into the proc_* registers (they stay stable until the next accept), clear the counter, go to S_RUN.
- S_RUN:
  - proc_cmd=CMD_RUN.
  - The processor latches constants on the same edge it leaves its IDLE state, because proc_* are already stable.
  - The counter increments every cycle.
  - When proc_status==ST_RUNNING, go to S_WAIT with proc_cmd=0 from the next cycle.
- S_WAIT:
  - proc_cmd=0; the counter increments.
  - When proc_status==ST_COMPLETE, capture proc_sum, proc_pow_sum and the counter into res_*, set res_err=0, go to S_ACK.
- S_ACK:
  - proc_cmd=CMD_ACK.
  - When proc_status==ST_IDLE, go to S_RESULT.
- S_RESULT:
  - res_valid=1; res_* are held stable.
  - On res_valid&&res_ready, go to S_IDLE if res_err==0, otherwise go to S_HALT.
  - res_valid deasserts the cycle after the handshake.
- Timeout:
  - In S_RUN or S_WAIT, when the counter reaches TIMEOUT_CYCLES without a match, set res_err=1, res_sum=0, res_pow_sum=0, res_cycles=TIMEOUT_CYCLES, proc_cmd=0, and go to S_RESULT. No ACK is attempted.
  - Timeout has priority over a status match in the same cycle.
- S_HALT: job_ready=0, busy=1, proc_cmd=0 until nreset.
- Status values other than the one awaited (including undefined codes 3..15) are ignored; the sequencer keeps waiting.
- The counter saturates at 32'hFFFFFFFF and never wraps.
- job_valid while not in S_IDLE is ignored (job_ready=0); job_* are not sampled.
- niter=0 is not rejected; it is passed through unchanged.
- Reset mid-operation aborts the job immediately: proc_cmd=0, res_valid=0, captured results cleared.
- Minimum job latency, accept to res_valid, with a processor that answers RUN in 1 cycle: 3 cycles plus the processor run time plus the ACK turnaround.

Test Plan:
- Nominal job: processor model completes 60 cycles after RUN with sum=64'h1234_5000, pow_sum=64'hABCD_0000.
  - proc_cmd=1 for exactly 1 cycle.
  - res_valid with those values, res_cycles=61, res_err=0.
  - proc_cmd=2 until status returns to 0.
- Back-pressure: hold res_ready=0 for 20 cycles with result pending.
  - res_valid stays 1, res_* stable, job_ready=0.
  - Release: res_valid drops the next cycle, job_ready=1.
- Timeout: TIMEOUT_CYCLES=100, model never leaves RUNNING.
  - res_valid with res_err=1, sums 0, res_cycles=100.
  - After the handshake, job_ready stays 0 and proc_cmd=0 until nreset.
- Busy rejection: pulse job_valid with different constants while in S_WAIT.
  - proc_constK etc. unchanged; the new job is not accepted.
- Reset mid-run: assert nreset in S_WAIT.
  - All outputs reach their reset values asynchronously.
  - After release a new job completes normally with correct sums.
- Back-to-back jobs: job_valid held high with a second job and res_ready=1.
  - Second job accepted the cycle after the first result handshake.
  - proc_const* update only at that accept.

Source files
------------

// File: rtl/bs_job_sequencer.sv
// Host-side job sequencer for the Black-Scholes processor: accepts one job, drives RUN/ACK,
// captures the processor sums at COMPLETE and returns them with a cycle count and timeout flag.
module bs_job_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000,
    parameter logic [3:0]  CMD_RUN        = 4'd1,
    parameter logic [3:0]  CMD_ACK        = 4'd2,
    parameter logic [3:0]  ST_IDLE        = 4'd0,
    parameter logic [3:0]  ST_RUNNING     = 4'd1,
    parameter logic [3:0]  ST_COMPLETE    = 4'd2
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_niter,
    input  logic [63:0] job_constK,
    input  logic [63:0] job_const1,
    input  logic [63:0] job_const2,
    output logic [31:0] proc_niter,
    output logic [63:0] proc_constK,
    output logic [63:0] proc_const1,
    output logic [63:0] proc_const2,
    output logic [3:0]  proc_cmd,
    input  logic [3:0]  proc_status,
    input  logic [63:0] proc_sum,
    input  logic [63:0] proc_pow_sum,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_sum,
    output logic [63:0] res_pow_sum,
    output logic [31:0] res_cycles,
    output logic        res_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_ACK,
        S_RESULT,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] cnt;
    logic [31:0] cnt_inc;
    logic        accept;
    logic        counting;
    logic        timed_out;
    logic        complete_hit;

    // Control outputs are pure decodes of the state register, so no input reaches an output.
    assign job_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_RESULT);

    always_comb begin
        proc_cmd = 4'd0;
        case (state)
            S_RUN:   proc_cmd = CMD_RUN;
            S_ACK:   proc_cmd = CMD_ACK;
            default: proc_cmd = 4'd0;
        endcase
    end

    // The count includes the current cycle, and saturates instead of wrapping.
    assign cnt_inc      = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    assign accept       = job_ready && job_valid;
    assign counting     = (state == S_RUN) || (state == S_WAIT);
    assign timed_out    = counting && (cnt_inc >= TIMEOUT_CYCLES);
    assign complete_hit = (state == S_WAIT) && (proc_status == ST_COMPLETE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (job_valid) state_next = S_RUN;
            end
            S_RUN: begin
                if (timed_out)                        state_next = S_RESULT;
                else if (proc_status == ST_RUNNING)   state_next = S_WAIT;
            end
            S_WAIT: begin
                if (timed_out)                        state_next = S_RESULT;
                else if (proc_status == ST_COMPLETE)  state_next = S_ACK;
            end
            S_ACK: begin
                if (proc_status == ST_IDLE) state_next = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) state_next = res_err ? S_HALT : S_IDLE;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            proc_niter  <= 32'd0;
            proc_constK <= 64'd0;
            proc_const1 <= 64'd0;
            proc_const2 <= 64'd0;
            cnt         <= 32'd0;
            res_sum     <= 64'd0;
            res_pow_sum <= 64'd0;
            res_cycles  <= 32'd0;
            res_err     <= 1'b0;
        end else begin
            if (accept) begin
                proc_niter  <= job_niter;
                proc_constK <= job_constK;
                proc_const1 <= job_const1;
                proc_const2 <= job_const2;
                cnt         <= 32'd0;
            end else if (counting) begin
                cnt <= cnt_inc;
            end

            // Timeout wins over a status match observed in the same cycle.
            if (timed_out) begin
                res_sum     <= 64'd0;
                res_pow_sum <= 64'd0;
                res_cycles  <= TIMEOUT_CYCLES;
                res_err     <= 1'b1;
            end else if (complete_hit) begin
                res_sum     <= proc_sum;
                res_pow_sum <= proc_pow_sum;
                res_cycles  <= cnt_inc;
                res_err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bs_job_sequencer.sv
// Directed bench for bs_job_sequencer with a behavioural processor model that answers
// commands half a cycle after they appear (on the falling edge).
module tb_bs_job_sequencer;

    localparam logic [31:0] TMO = 32'd100;

    logic        clk = 1'b0;
    logic        nreset;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_niter;
    logic [63:0] job_constK, job_const1, job_const2;
    logic [31:0] proc_niter;
    logic [63:0] proc_constK, proc_const1, proc_const2;
    logic [3:0]  proc_cmd;
    logic [3:0]  proc_status;
    logic [63:0] proc_sum, proc_pow_sum;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_sum, res_pow_sum;
    logic [31:0] res_cycles;
    logic        res_err;
    logic        busy;

    int passed = 0;
    int total  = 0;

    // Processor model knobs
    int          run_len = 10;
    int          remain  = 0;
    bit          hang    = 1'b0;
    logic [63:0] m_sum   = 64'd0;
    logic [63:0] m_pow   = 64'd0;

    always #5 clk = ~clk;

    bs_job_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_niter   (job_niter),
        .job_constK  (job_constK),
        .job_const1  (job_const1),
        .job_const2  (job_const2),
        .proc_niter  (proc_niter),
        .proc_constK (proc_constK),
        .proc_const1 (proc_const1),
        .proc_const2 (proc_const2),
        .proc_cmd    (proc_cmd),
        .proc_status (proc_status),
        .proc_sum    (proc_sum),
        .proc_pow_sum(proc_pow_sum),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_pow_sum (res_pow_sum),
        .res_cycles  (res_cycles),
        .res_err     (res_err),
        .busy        (busy)
    );

    // Sums are only valid while the model reports COMPLETE, so a mistimed capture shows up.
    assign proc_sum     = (proc_status == 4'd2) ? m_sum : 64'hDEAD_BEEF_DEAD_BEEF;
    assign proc_pow_sum = (proc_status == 4'd2) ? m_pow : 64'hBAD0_BAD0_BAD0_BAD0;

    // IDLE -RUN-> RUNNING, COMPLETE run_len falling edges later, -ACK-> IDLE.
    always @(negedge clk or negedge nreset) begin
        if (!nreset) begin
            proc_status <= 4'd0;
            remain      <= 0;
        end else begin
            case (proc_status)
                4'd0: if (proc_cmd == 4'd1) begin
                    proc_status <= 4'd1;
                    remain      <= run_len - 1;
                end
                4'd1: if (!hang) begin
                    if (remain == 0) proc_status <= 4'd2;
                    else             remain      <= remain - 1;
                end
                4'd2: if (proc_cmd == 4'd2) proc_status <= 4'd0;
                default: proc_status <= 4'd0;
            endcase
        end
    end

    // Present a job for one cycle; returns on the falling edge of the first RUN cycle.
    task automatic start_job(input logic [31:0] n, input logic [63:0] k, input logic [63:0] c1,
                             input logic [63:0] c2);
        job_niter  = n;
        job_constK = k;
        job_const1 = c1;
        job_const2 = c2;
        job_valid  = 1'b1;
        @(negedge clk);
        job_valid  = 1'b0;
    endtask

    task automatic wait_res(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits for S_WAIT as seen from outside: processor RUNNING and RUN withdrawn.
    task automatic wait_wait_state(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (busy && proc_status == 4'd1 && proc_cmd == 4'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_result;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        nreset = 1'b1;
        #2 nreset = 1'b0;
        #1;
        total++;
        if ({job_ready, busy, proc_cmd, res_valid, res_err} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_ctrl: got ready=%b busy=%b cmd=%0d valid=%b err=%b, expected 1 0 0 0 0",
                     job_ready, busy, proc_cmd, res_valid, res_err);
        else passed++;
        total++;
        if ({res_sum, res_pow_sum, res_cycles, proc_niter, proc_constK} !== '0)
            $display("FAIL reset_data: got sum=%h pow=%h cyc=%0d niter=%0d K=%h, expected all 0",
                     res_sum, res_pow_sum, res_cycles, proc_niter, proc_constK);
        else passed++;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        total++;
        if (job_ready !== 1'b1 || proc_cmd !== 4'd0)
            $display("FAIL reset_release: got ready=%b cmd=%0d, expected 1 0", job_ready, proc_cmd);
        else passed++;
    endtask

    task automatic test_nominal;
        int run_cycles = 0;
        int ack_cycles = 0;
        int ack_bad    = 0;
        bit ok         = 1'b0;
        m_sum   = 64'h1234_5000;
        m_pow   = 64'hABCD_0000;
        run_len = 60;
        start_job(32'd5000, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 64'h3333_0000_0000_0003);
        total++;
        if ({proc_niter, proc_constK, proc_const1, proc_const2} !==
            {32'd5000, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 64'h3333_0000_0000_0003})
            $display("FAIL nominal_latch: got niter=%0d K=%h c1=%h c2=%h", proc_niter, proc_constK,
                     proc_const1, proc_const2);
        else passed++;
        for (int i = 0; i < 200; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            if (proc_cmd == 4'd1) run_cycles++;
            if (proc_cmd == 4'd2) begin
                ack_cycles++;
                if (proc_status == 4'd0) ack_bad++;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) $display("FAIL nominal_res_valid: got no result within 200 cycles, expected one");
        else passed++;
        total++;
        if (run_cycles != 1) $display("FAIL nominal_run_cmd: got %0d RUN cycles, expected 1", run_cycles);
        else passed++;
        // The model drops COMPLETE on the falling edge of the first ACK cycle.
        total++;
        if (ack_cycles != 1 || ack_bad != 0)
            $display("FAIL nominal_ack_cmd: got %0d ACK cycles (%0d after IDLE), expected 1 (0)",
                     ack_cycles, ack_bad);
        else passed++;
        total++;
        if (res_sum !== 64'h1234_5000 || res_pow_sum !== 64'hABCD_0000)
            $display("FAIL nominal_sums: got %h %h, expected 0000000012345000 00000000abcd0000",
                     res_sum, res_pow_sum);
        else passed++;
        total++;
        if (res_cycles !== 32'd61 || res_err !== 1'b0)
            $display("FAIL nominal_cycles: got cycles=%0d err=%b, expected 61 0", res_cycles, res_err);
        else passed++;
        total++;
        if (proc_cmd !== 4'd0 || proc_status !== 4'd0)
            $display("FAIL nominal_after_ack: got cmd=%0d status=%0d, expected 0 0", proc_cmd, proc_status);
        else passed++;
    endtask

    // Continues from the pending nominal result.
    task automatic test_back_pressure;
        res_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            total++;
            if ({res_valid, job_ready, busy, res_sum, res_pow_sum, res_cycles} !==
                {1'b1, 1'b0, 1'b1, 64'h1234_5000, 64'hABCD_0000, 32'd61})
                $display("FAIL backpressure_hold[%0d]: got valid=%b ready=%b busy=%b sum=%h pow=%h cyc=%0d",
                         i, res_valid, job_ready, busy, res_sum, res_pow_sum, res_cycles);
            else passed++;
            @(negedge clk);
        end
        release_result();
        total++;
        if ({res_valid, job_ready, busy} !== 3'b010)
            $display("FAIL backpressure_release: got valid=%b ready=%b busy=%b, expected 0 1 0",
                     res_valid, job_ready, busy);
        else passed++;
    endtask

    task automatic test_busy_reject;
        bit ok;
        m_sum   = 64'h0000_2222;
        m_pow   = 64'h0000_3333;
        run_len = 40;
        start_job(32'd77, 64'hAAAA, 64'hBBBB, 64'hCCCC);
        wait_wait_state(20, ok);
        total++;
        if (!ok) $display("FAIL reject_reach_wait: got no WAIT state within 20 cycles, expected it");
        else passed++;
        job_niter  = 32'd99;
        job_constK = 64'h1;
        job_const1 = 64'h2;
        job_const2 = 64'h3;
        job_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({job_ready, proc_niter, proc_constK, proc_const1, proc_const2} !==
                {1'b0, 32'd77, 64'hAAAA, 64'hBBBB, 64'hCCCC})
                $display("FAIL reject_hold[%0d]: got ready=%b niter=%0d K=%h c1=%h c2=%h", i, job_ready,
                         proc_niter, proc_constK, proc_const1, proc_const2);
            else passed++;
        end
        job_valid = 1'b0;
        wait_res(100, ok);
        total++;
        if (!ok || res_sum !== 64'h2222 || res_pow_sum !== 64'h3333 || res_cycles !== 32'd41)
            $display("FAIL reject_result: got ok=%b sum=%h pow=%h cyc=%0d, expected 1 2222 3333 41",
                     ok, res_sum, res_pow_sum, res_cycles);
        else passed++;
        release_result();
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || proc_constK !== 64'hAAAA)
            $display("FAIL reject_not_taken: got busy=%b K=%h, expected 0 aaaa", busy, proc_constK);
        else passed++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        m_sum      = 64'h0A0A;
        m_pow      = 64'h0B0B;
        run_len    = 10;
        res_ready  = 1'b1;
        job_niter  = 32'd10;
        job_constK = 64'hA1;
        job_const1 = 64'hA2;
        job_const2 = 64'hA3;
        job_valid  = 1'b1;
        @(negedge clk);
        job_niter  = 32'd0;
        job_constK = 64'hB1;
        job_const1 = 64'hB2;
        job_const2 = 64'hB3;
        total++;
        if (proc_constK !== 64'hA1 || proc_cmd !== 4'd1)
            $display("FAIL b2b_first_accept: got K=%h cmd=%0d, expected a1 1", proc_constK, proc_cmd);
        else passed++;
        wait_res(50, ok);
        total++;
        if (!ok || res_sum !== 64'h0A0A || res_cycles !== 32'd11 || proc_constK !== 64'hA1)
            $display("FAIL b2b_first_result: got ok=%b sum=%h cyc=%0d K=%h, expected 1 a0a 11 a1",
                     ok, res_sum, res_cycles, proc_constK);
        else passed++;
        m_sum   = 64'h0C0C;
        m_pow   = 64'h0D0D;
        run_len = 5;
        @(negedge clk);
        total++;
        if ({res_valid, job_ready, proc_constK} !== {1'b0, 1'b1, 64'hA1})
            $display("FAIL b2b_idle_gap: got valid=%b ready=%b K=%h, expected 0 1 a1",
                     res_valid, job_ready, proc_constK);
        else passed++;
        @(negedge clk);
        job_valid = 1'b0;
        total++;
        if ({proc_niter, proc_constK, proc_const1, proc_const2, proc_cmd} !==
            {32'd0, 64'hB1, 64'hB2, 64'hB3, 4'd1})
            $display("FAIL b2b_second_accept: got niter=%0d K=%h c1=%h c2=%h cmd=%0d", proc_niter,
                     proc_constK, proc_const1, proc_const2, proc_cmd);
        else passed++;
        wait_res(50, ok);
        total++;
        if (!ok || res_sum !== 64'h0C0C || res_pow_sum !== 64'h0D0D || res_cycles !== 32'd6)
            $display("FAIL b2b_second_result: got ok=%b sum=%h pow=%h cyc=%0d, expected 1 c0c d0d 6",
                     ok, res_sum, res_pow_sum, res_cycles);
        else passed++;
        @(negedge clk);
        res_ready = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_done: got busy=%b, expected 0", busy);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        m_sum   = 64'h5555;
        m_pow   = 64'h6666;
        run_len = 50;
        start_job(32'd123, 64'hC1, 64'hC2, 64'hC3);
        wait_wait_state(20, ok);
        total++;
        if (!ok) $display("FAIL midreset_reach_wait: got no WAIT state within 20 cycles, expected it");
        else passed++;
        repeat (5) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        total++;
        if ({job_ready, busy, proc_cmd, res_valid, res_err} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL midreset_ctrl: got ready=%b busy=%b cmd=%0d valid=%b err=%b, expected 1 0 0 0 0",
                     job_ready, busy, proc_cmd, res_valid, res_err);
        else passed++;
        total++;
        if ({res_sum, res_pow_sum, res_cycles, proc_niter, proc_constK, proc_const1, proc_const2} !== '0)
            $display("FAIL midreset_data: got sum=%h cyc=%0d niter=%0d K=%h, expected all 0",
                     res_sum, res_cycles, proc_niter, proc_constK);
        else passed++;
        @(negedge clk);
        nreset  = 1'b1;
        @(negedge clk);
        m_sum   = 64'h7777;
        m_pow   = 64'h8888;
        run_len = 8;
        start_job(32'd9, 64'hD1, 64'hD2, 64'hD3);
        wait_res(50, ok);
        total++;
        if (!ok || res_sum !== 64'h7777 || res_pow_sum !== 64'h8888 || res_cycles !== 32'd9 || res_err !== 1'b0)
            $display("FAIL midreset_rerun: got ok=%b sum=%h pow=%h cyc=%0d err=%b, expected 1 7777 8888 9 0",
                     ok, res_sum, res_pow_sum, res_cycles, res_err);
        else passed++;
        release_result();
    endtask

    task automatic test_timeout;
        bit ok        = 1'b0;
        int ack_seen  = 0;
        hang    = 1'b1;
        run_len = 10;
        start_job(32'd1, 64'hE1, 64'hE2, 64'hE3);
        for (int i = 0; i < 300; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            if (proc_cmd == 4'd2) ack_seen++;
            @(negedge clk);
        end
        total++;
        if (!ok) $display("FAIL timeout_res_valid: got no result within 300 cycles, expected one");
        else passed++;
        total++;
        if ({res_err, res_sum, res_pow_sum, res_cycles} !== {1'b1, 64'd0, 64'd0, TMO})
            $display("FAIL timeout_result: got err=%b sum=%h pow=%h cyc=%0d, expected 1 0 0 100",
                     res_err, res_sum, res_pow_sum, res_cycles);
        else passed++;
        total++;
        if (ack_seen != 0 || proc_cmd !== 4'd0)
            $display("FAIL timeout_no_ack: got %0d ACK cycles cmd=%0d, expected 0 0", ack_seen, proc_cmd);
        else passed++;
        release_result();
        job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({job_ready, busy, proc_cmd, res_valid} !== {1'b0, 1'b1, 4'd0, 1'b0})
                $display("FAIL timeout_halt[%0d]: got ready=%b busy=%b cmd=%0d valid=%b, expected 0 1 0 0",
                         i, job_ready, busy, proc_cmd, res_valid);
            else passed++;
            @(negedge clk);
        end
        job_valid = 1'b0;
        hang      = 1'b0;
        #2 nreset = 1'b0;
        #1;
        total++;
        if (job_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL timeout_exit_reset: got ready=%b busy=%b, expected 1 0", job_ready, busy);
        else passed++;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        job_valid  = 1'b0;
        res_ready  = 1'b0;
        job_niter  = 32'd0;
        job_constK = 64'd0;
        job_const1 = 64'd0;
        job_const2 = 64'd0;
        test_reset();
        test_nominal();
        test_back_pressure();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid_run();
        test_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
